// File: rtl/cpu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cpu_sequencer_pkg
// Shared definitions for the multi-cycle CPU sequencer and the decode logic.
//   state_e          : sequencer state encoding (visible on the state port)
//   MEM_TIMEOUT_DEF  : default memory timeout, in request cycles
//   WAIT_W           : width of the memory wait counter (covers 1..255)
//   FUNCT_HALT       : funct field value that decodes as halt
//   is_active()      : true for states that count toward cycle_count
// -----------------------------------------------------------------------------
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERROR  = 3'd7
  } state_e;

  localparam int unsigned MEM_TIMEOUT_DEF = 16;
  localparam int          WAIT_W          = 8;
  localparam logic [5:0]  FUNCT_HALT      = 6'b111111;

  function automatic logic is_active(state_e s);
    return !(s == ST_IDLE || s == ST_HALT || s == ST_ERROR);
  endfunction

endpackage

// File: rtl/cpu_sequencer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears the count
//   inc : count enable
//   q   : current count (W bits)
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle sequencer stepping each instruction through FETCH, DECODE,
// EXEC, MEM and WB over one shared memory port.
//   inputs : clk, rst (async, active-high), run, dec_* class flags,
//            branch_taken (valid in EXEC), mem_ready
//   outputs: mem_req/mem_we, ir_write, mdr_write, pc_write, pc_src,
//            reg_write, state, halted, err, cycle_count, instr_count
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for run at an instruction boundary
// FETCH  | instruction read on the memory port
// DECODE | one cycle for the decode flags to settle; halt/illegal check
// EXEC   | ALU cycle; branches and nops retire here
// MEM    | load/store transfer on the memory port
// WB     | register file write, then retire
// HALT   | halt instruction seen; leaves only on reset
// ERROR  | memory timeout or illegal load+store; leaves only on reset
// -----------------------------------------------------------------------------
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_branch,
  input  logic             dec_reg_write,
  input  logic             dec_halt,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic [2:0]       state,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  // Timeout fires at the end of the MEM_TIMEOUT-th stalled request cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    retire  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
          wait_d  = '0;
        end
      end
      ST_FETCH: begin
        if (mem_ready)                state_d = ST_DECODE;
        else if (wait_q == WAIT_LAST) state_d = ST_ERROR;
        else                          wait_d  = wait_q + WAIT_W'(1);
      end
      ST_DECODE: begin
        if (dec_halt)                          state_d = ST_HALT;
        else if (dec_mem_read && dec_mem_write) state_d = ST_ERROR;
        else                                   state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_branch) begin
          retire = 1'b1;
        end else if (dec_mem_read || dec_mem_write) begin
          state_d = ST_MEM;
          wait_d  = '0;
        end else if (dec_reg_write) begin
          state_d = ST_WB;
        end else begin
          retire = 1'b1;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          // Load and store are mutually exclusive here; DECODE traps both.
          if (dec_mem_read) state_d = ST_WB;
          else              retire  = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_ERROR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WB:    retire = 1'b1;
      ST_HALT:  state_d = ST_HALT;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
    // run is only looked at here, so dropping it mid-instruction is harmless.
    if (retire) begin
      state_d = run ? ST_FETCH : ST_IDLE;
      wait_d  = '0;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    reg_write = 1'b0;
    halted    = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      ST_EXEC: begin
        if (dec_branch) begin
          pc_src   = 1'b1;
          pc_write = branch_taken;
        end
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        mem_we    = dec_mem_write;
        mdr_write = mem_ready && dec_mem_read;
      end
      ST_WB:    reg_write = 1'b1;
      ST_HALT:  halted    = 1'b1;
      ST_ERROR: err       = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .inc (is_active(state_q)),
    .q   (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk (clk),
    .rst (rst),
    .inc (retire),
    .q   (instr_count)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
// Scoreboard bench: each driven cycle pushes the expected state/enables,
// a negedge monitor pops and compares. Counters are checked directly.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

  localparam int TO = 4;

  // Input bundle: {run, rd, wr, br, rw, halt, taken, ready}
  localparam logic [7:0] RUN = 8'h80, RD = 8'h40, WR = 8'h20, BR = 8'h10;
  localparam logic [7:0] RW  = 8'h08, HLT = 8'h04, TK = 8'h02, RDY = 8'h01;

  // Enables: {mem_req, mem_we, ir_write, mdr_write, pc_write, pc_src, reg_write}
  localparam logic [6:0] E0    = 7'b0000000;
  localparam logic [6:0] E_FT  = 7'b1010100;
  localparam logic [6:0] E_REQ = 7'b1000000;
  localparam logic [6:0] E_MDR = 7'b1001000;
  localparam logic [6:0] E_ST  = 7'b1100000;
  localparam logic [6:0] E_WB  = 7'b0000001;
  localparam logic [6:0] E_BRT = 7'b0000110;
  localparam logic [6:0] E_BRN = 7'b0000010;

  logic clk = 1'b0;
  logic rst;
  logic run, dec_mem_read, dec_mem_write, dec_branch, dec_reg_write, dec_halt;
  logic branch_taken, mem_ready;
  logic mem_req, mem_we, ir_write, mdr_write, pc_write, pc_src, reg_write;
  logic [2:0] state;
  logic halted, err;
  logic [31:0] cycle_count, instr_count;

  always #5 clk = ~clk;

  cpu_sequencer #(.CNT_W(32), .MEM_TIMEOUT(TO)) dut (
    .clk (clk), .rst (rst), .run (run),
    .dec_mem_read (dec_mem_read), .dec_mem_write (dec_mem_write),
    .dec_branch (dec_branch), .dec_reg_write (dec_reg_write),
    .dec_halt (dec_halt), .branch_taken (branch_taken), .mem_ready (mem_ready),
    .mem_req (mem_req), .mem_we (mem_we), .ir_write (ir_write),
    .mdr_write (mdr_write), .pc_write (pc_write), .pc_src (pc_src),
    .reg_write (reg_write), .state (state), .halted (halted), .err (err),
    .cycle_count (cycle_count), .instr_count (instr_count)
  );

  logic [11:0] obs;
  assign obs = {state, mem_req, mem_we, ir_write, mdr_write, pc_write, pc_src,
                reg_write, halted, err};

  typedef struct {
    string       tag;
    logic [11:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ev(int st, logic [6:0] en);
    return {3'(st), en, (st == 6) ? 1'b1 : 1'b0, (st == 7) ? 1'b1 : 1'b0};
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, {52'd0, obs}, {52'd0, e.v});
    end
  end

  // Drive one cycle's inputs, queue what the DUT must show, advance a cycle.
  task automatic cyc(string tag, logic [7:0] in_v, int st, logic [6:0] en);
    exp_t e;
    {run, dec_mem_read, dec_mem_write, dec_branch, dec_reg_write, dec_halt,
     branch_taken, mem_ready} = in_v;
    e.tag = tag;
    e.v   = ev(st, en);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic cnt(string tag, int c, int i);
    check({tag, "_cycles"}, 64'(cycle_count), 64'(c));
    check({tag, "_instrs"}, 64'(instr_count), 64'(i));
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    #1;
    check({tag, "_outs"}, {52'd0, obs}, 64'd0);
    cnt(tag, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {run, dec_mem_read, dec_mem_write, dec_branch, dec_reg_write, dec_halt,
     branch_taken, mem_ready} = 8'h00;
    #2;
    check("reset_outs", {52'd0, obs}, 64'd0);
    cnt("reset", 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ALU op: 4 cycles
    cyc("alu_idle",  RUN | RW | RDY, 0, E0);
    cyc("alu_fetch", RUN | RW | RDY, 1, E_FT);
    cyc("alu_dec",   RUN | RW | RDY, 2, E0);
    cyc("alu_exec",  RUN | RW | RDY, 3, E0);
    cyc("alu_wb",    RUN | RW,       5, E_WB);
    cnt("alu", 4, 1);

    // Load, memory stalls 2 cycles: 7 cycles
    cyc("ld_fetch",   RUN | RD | RW | RDY, 1, E_FT);
    cyc("ld_dec",     RUN | RD | RW,       2, E0);
    cyc("ld_exec",    RUN | RD | RW | RDY, 3, E0);
    cyc("ld_mem_w1",  RUN | RD | RW,       4, E_REQ);
    cyc("ld_mem_w2",  RUN | RD | RW,       4, E_REQ);
    cyc("ld_mem_rdy", RUN | RD | RW | RDY, 4, E_MDR);
    cyc("ld_wb",      RUN | RD | RW,       5, E_WB);
    cnt("load", 11, 2);

    // Branch taken, then not taken: 3 cycles each
    cyc("bt_fetch", RUN | BR | TK | RDY, 1, E_FT);
    cyc("bt_dec",   RUN | BR | TK,       2, E0);
    cyc("bt_exec",  RUN | BR | TK,       3, E_BRT);
    cyc("bn_fetch", RUN | BR | RDY,      1, E_FT);
    cyc("bn_dec",   RUN | BR,            2, E0);
    cyc("bn_exec",  RUN | BR,            3, E_BRN);
    cnt("branch", 17, 4);

    // Store with run dropped in MEM: completes, then IDLE
    cyc("st_fetch",   RUN | WR | RDY, 1, E_FT);
    cyc("st_dec",     RUN | WR,       2, E0);
    cyc("st_exec",    RUN | WR,       3, E0);
    cyc("st_mem_w",   WR,             4, E_ST);
    cyc("st_mem_rdy", WR | RDY,       4, E_ST);
    cnt("store", 22, 5);
    cyc("st_idle",    RDY,            0, E0);
    cnt("idle", 22, 5);

    // Fetch timeout: ERROR after exactly TO stalled request cycles
    cyc("to_idle", RUN, 0, E0);
    for (int i = 0; i < TO; i++) cyc("to_fetch", RUN, 1, E_REQ);
    for (int i = 0; i < 3; i++)  cyc("to_err", RUN | RDY, 7, E0);
    cnt("timeout", 26, 5);
    do_reset("rst1");

    // mem_ready on the last allowed cycle wins
    cyc("rt_idle", RUN, 0, E0);
    for (int i = 0; i < TO - 1; i++) cyc("rt_wait", RUN, 1, E_REQ);
    cyc("rt_rdy",   RUN | RDY, 1, E_FT);
    cyc("rt_dec",   8'h00,     2, E0);
    cyc("rt_exec",  8'h00,     3, E0);
    cyc("rt_idle2", RDY,       0, E0);
    cnt("retry", 6, 1);

    // Halt: counters frozen
    cyc("h_idle",  RUN,       0, E0);
    cyc("h_fetch", RUN | RDY, 1, E_FT);
    cyc("h_dec",   RUN | HLT, 2, E0);
    cnt("halt_in", 8, 1);
    for (int i = 0; i < 10; i++) cyc("h_halt", RUN | RW | RDY, 6, E0);
    cnt("halt_hold", 8, 1);
    do_reset("rst2");

    // Load and store both set -> ERROR
    cyc("cf_idle",  RUN,            0, E0);
    cyc("cf_fetch", RUN | RDY,      1, E_FT);
    cyc("cf_dec",   RUN | RD | WR,  2, E0);
    for (int i = 0; i < 3; i++) cyc("cf_err", RUN | RDY, 7, E0);
    cnt("conflict", 2, 0);
    do_reset("rst3");

    // Reset while in WB
    cyc("rw_idle",  RUN | RW | RDY, 0, E0);
    cyc("rw_fetch", RUN | RW | RDY, 1, E_FT);
    cyc("rw_dec",   RUN | RW,       2, E0);
    cyc("rw_exec",  RUN | RW,       3, E0);
    {run, dec_mem_read, dec_mem_write, dec_branch, dec_reg_write, dec_halt,
     branch_taken, mem_ready} = RUN | RW;
    #1;
    check("rw_wb_pre", {52'd0, obs}, {52'd0, ev(5, E_WB)});
    do_reset("rst_wb");

    // Reset mid-fetch drops mem_req at once
    cyc("mr_idle", RUN, 0, E0);
    {run, dec_mem_read, dec_mem_write, dec_branch, dec_reg_write, dec_halt,
     branch_taken, mem_ready} = RUN;
    #1;
    check("mr_fetch_pre", {52'd0, obs}, {52'd0, ev(1, E_REQ)});
    do_reset("rst_fetch");

    repeat (2) @(posedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
